// File: rtl/pkt_framing_reader.sv
// Packet FIFO read-side consumer: SOP/EOP framing check, orphan drop,
// registered main+skid output stage and saturating statistics counters.
module pkt_framing_reader #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               in_error,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_error,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               error;
    } beat_t;

    state_t state, state_nxt;
    beat_t  beat, main_q, skid_q;
    logic   main_v, skid_v;
    logic   accept, orphan, fwd, drain;

    assign accept = in_valid && in_ready;
    assign fwd    = accept && !orphan;
    assign drain  = main_v && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        orphan     = 1'b0;
        beat.data  = in_data;
        beat.sop   = in_sop;
        beat.eop   = in_eop;
        beat.empty = in_empty;
        beat.error = in_error;
        // empty is only meaningful on the last beat of a packet
        if (!in_eop && in_empty != '0) begin
            beat.error = 1'b1;
            beat.empty = '0;
        end
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_sop) state_nxt = in_eop ? IDLE : IN_PKT;
                    else        orphan    = 1'b1;
                end
            end
            IN_PKT: begin
                if (accept) begin
                    if (in_sop) beat.error = 1'b1;
                    state_nxt = in_eop ? IDLE : IN_PKT;
                end
            end
        endcase
    end

    // skid is only ever filled while main is stalled, so accept implies skid empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain || !main_v) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (fwd) begin
                main_q <= beat;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (fwd) begin
            skid_q <= beat;
            skid_v <= 1'b1;
        end
    end

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q.data;
    assign out_sop   = main_q.sop;
    assign out_eop   = main_q.eop;
    assign out_empty = main_q.empty;
    assign out_error = main_q.error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (drain && main_q.eop && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + 1'b1;
            if (drain && main_q.eop && main_q.error && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (accept && orphan && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
